// File: rtl/banner_scroll_ctrl.sv
// Banner scroll controller: steps a horizontal scroll offset on frame
// boundaries and answers per-pixel lookups against the selected banner ROM
// through a fixed two-stage pipeline.
module banner_scroll_ctrl #(
  parameter int WIDTH    = 71,
  parameter int ROWS     = 15,
  parameter int SCREEN_W = 32,
  parameter int TICK_DIV = 1500000,
  parameter int NWORDS   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [2:0]       word_sel,
  input  logic             frame_start,
  input  logic             pix_req,
  input  logic [4:0]       pix_x,
  input  logic [3:0]       pix_y,
  output logic [2:0]       rom_sel,
  output logic [4:0]       rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic             pix_valid,
  output logic             pix_on,
  output logic             busy,
  output logic             done
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [6:0]    OFF_LAST  = 7'(WIDTH + SCREEN_W - 1);
  localparam logic [7:0]    SUM_LO    = 8'(SCREEN_W);
  localparam logic [7:0]    SUM_HI    = 8'(SCREEN_W + WIDTH);
  localparam logic [4:0]    ROWS_LIM  = 5'(ROWS);
  localparam logic [6:0]    COL_MSB   = 7'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_reg, state_next;
  logic [6:0]      offset_reg, offset_next;
  logic [TW-1:0]   tick_reg, tick_next;
  logic            pending_reg, pending_next;
  logic [2:0]      rom_sel_reg, rom_sel_next;
  logic            done_reg, done_next;
  logic            busy_reg;
  logic            tick_wrap;
  logic            word_ok;

  // Lookup pipeline
  logic [7:0]      sum;
  logic            vis_next, vis_reg;
  logic [6:0]      col_next, col_reg;
  logic [6:0]      bit_idx;
  logic            req_d1_reg;
  logic            pix_valid_reg, pix_on_reg;

  assign tick_wrap = (state_reg == S_RUN) && (tick_reg == TICK_LAST);
  assign word_ok   = 32'(word_sel) < NWORDS;

  // Next-state logic: stop beats start, start (re)arms, RUN ticks and steps
  always_comb begin
    state_next   = state_reg;
    offset_next  = offset_reg;
    tick_next    = tick_reg;
    pending_next = pending_reg;
    rom_sel_next = rom_sel_reg;
    done_next    = 1'b0;
    if (stop) begin
      state_next   = S_IDLE;
      offset_next  = '0;
      tick_next    = '0;
      pending_next = 1'b0;
    end else if (start) begin
      state_next   = S_RUN;
      offset_next  = '0;
      tick_next    = '0;
      pending_next = 1'b0;
      rom_sel_next = word_ok ? word_sel : 3'd0;
    end else if (state_reg == S_RUN) begin
      tick_next    = tick_wrap ? '0 : tick_reg + TW'(1);
      pending_next = pending_reg | tick_wrap;
      // A pending step is consumed only at a frame boundary to avoid tearing
      if (frame_start && pending_reg) begin
        pending_next = tick_wrap;
        if (offset_reg != OFF_LAST) begin
          offset_next = offset_reg + 7'd1;
        end else if (loop_en) begin
          offset_next = '0;
        end else begin
          state_next  = S_IDLE;
          offset_next = '0;
          tick_next   = '0;
          done_next   = 1'b1;
        end
      end
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      offset_reg  <= '0;
      tick_reg    <= '0;
      pending_reg <= 1'b0;
      rom_sel_reg <= 3'd0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      offset_reg  <= offset_next;
      tick_reg    <= tick_next;
      pending_reg <= pending_next;
      rom_sel_reg <= rom_sel_next;
      done_reg    <= done_next;
      busy_reg    <= (state_next == S_RUN);
    end
  end

  // Stage 0: screen column plus offset lands in banner space at sum-SCREEN_W
  always_comb begin
    sum      = {3'b000, pix_x} + {1'b0, offset_reg};
    vis_next = pix_req && (state_reg == S_RUN) && ({1'b0, pix_y} < ROWS_LIM) &&
               (sum >= SUM_LO) && (sum < SUM_HI);
    // Column forced to 0 when invisible so the ROM bit select stays in range
    col_next = vis_next ? 7'(sum - SUM_LO) : 7'd0;
  end

  assign bit_idx = COL_MSB - col_reg;

  // Two-stage lookup pipeline; rom_data lines up with the stage-1 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vis_reg       <= 1'b0;
      col_reg       <= '0;
      req_d1_reg    <= 1'b0;
      pix_valid_reg <= 1'b0;
      pix_on_reg    <= 1'b0;
    end else begin
      vis_reg       <= vis_next;
      col_reg       <= col_next;
      req_d1_reg    <= pix_req;
      pix_valid_reg <= req_d1_reg;
      pix_on_reg    <= vis_reg & rom_data[bit_idx];
    end
  end

  assign rom_addr  = {1'b0, pix_y};
  assign rom_sel   = rom_sel_reg;
  assign pix_valid = pix_valid_reg;
  assign pix_on    = pix_on_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Testbench for banner_scroll_ctrl: behavioural ROM, offset/state model and a
// lookup scoreboard keyed on the cycle each result is due.
module tb_banner_scroll_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop_en, frame_start, pix_req;
  logic [2:0]  word_sel;
  logic [4:0]  pix_x;
  logic [3:0]  pix_y;
  logic [2:0]  rom_sel;
  logic [4:0]  rom_addr;
  logic [70:0] rom_data = '0;
  logic        pix_valid, pix_on, busy, done;

  banner_scroll_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .word_sel(word_sel), .frame_start(frame_start), .pix_req(pix_req),
    .pix_x(pix_x), .pix_y(pix_y), .rom_sel(rom_sel), .rom_addr(rom_addr),
    .rom_data(rom_data), .pix_valid(pix_valid), .pix_on(pix_on),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int n_pix = 0;

  typedef struct { logic on; int due; } sb_t;
  sb_t sb[$];

  typedef struct { int x; int y; logic exp_on; } vec_t;
  vec_t vtab[11];

  // Model of the controller as seen by the bench
  logic m_run = 1'b0;
  logic m_loop = 1'b0;
  int   m_off = 0;
  int   m_word = 0;
  int   m_start_cyc = 0;

  function automatic logic pix_bit(input int w, input int r, input int c);
    return ((c * 5 + r * 7 + w * 3) % 4) == 1;
  endfunction

  function automatic logic [70:0] rom_word(input int w, input int r);
    logic [70:0] v;
    v = '0;
    if (r < 15)
      for (int c = 0; c < 71; c++) v[70 - c] = pix_bit(w, r, c);
    return v;
  endfunction

  function automatic logic exp_pix(input int x, input int y);
    int s;
    s = x + m_off;
    if (!m_run || y >= 15 || s < 32 || s >= 103) return 1'b0;
    return pix_bit(m_word, y, s - 32);
  endfunction

  // Behavioural banner ROM with one cycle of read latency
  always @(posedge clk) rom_data <= rom_word(int'(rom_sel), int'(rom_addr));

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: each result must appear exactly on its due cycle
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      sb_t e;
      e = sb.pop_front();
      n_pix++;
      $display("pix %0d cycle %0d: valid=%0d on=%0d exp_on=%0d", n_pix, cyc, pix_valid, pix_on, e.on);
      chk("pix_valid", int'(pix_valid), 1);
      chk("pix_on", int'(pix_on), int'(e.on));
    end else if (pix_valid === 1'b1) begin
      chk("pix_valid_unexpected", int'(pix_valid), 0);
    end
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (3) tick();
  endtask

  task automatic do_req(input int x, input int y, input logic e);
    pix_req = 1'b1;
    pix_x   = 5'(x);
    pix_y   = 4'(y);
    sb.push_back('{on: e, due: cyc + 2});
    #1;
    chk("rom_addr", int'(rom_addr), y);
    tick();
    pix_req = 1'b0;
  endtask

  task automatic do_start(input int w, input logic l);
    word_sel = 3'(w);
    loop_en  = l;
    start    = 1'b1;
    tick();
    start = 1'b0;
    m_run = 1'b1; m_off = 0; m_word = w; m_loop = l; m_start_cyc = cyc;
  endtask

  task automatic step(input int wait_cyc);
    repeat (wait_cyc) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (m_run) begin
      if (m_off < 102) m_off++;
      else if (m_loop) m_off = 0;
      else begin m_run = 1'b0; m_off = 0; end
    end
  endtask

  initial begin
    // Offset 32, word 0: banner column equals screen column
    vtab[0]  = '{x: 0,  y: 3,  exp_on: 1'b1};
    vtab[1]  = '{x: 0,  y: 0,  exp_on: 1'b0};
    vtab[2]  = '{x: 17, y: 0,  exp_on: 1'b1};
    vtab[3]  = '{x: 0,  y: 15, exp_on: 1'b0};
    vtab[4]  = '{x: 1,  y: 0,  exp_on: 1'b1};
    vtab[5]  = '{x: 5,  y: 2,  exp_on: 1'b0};
    vtab[6]  = '{x: 10, y: 1,  exp_on: 1'b1};
    vtab[7]  = '{x: 3,  y: 1,  exp_on: 1'b0};
    vtab[8]  = '{x: 31, y: 14, exp_on: 1'b1};
    vtab[9]  = '{x: 2,  y: 5,  exp_on: 1'b1};
    vtab[10] = '{x: 4,  y: 4,  exp_on: 1'b0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; word_sel = 3'd0;
    frame_start = 1'b0; pix_req = 1'b0; pix_x = 5'd0; pix_y = 4'd0;
    repeat (3) tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_pix_valid", int'(pix_valid), 0);
    chk("reset_pix_on", int'(pix_on), 0);
    chk("reset_rom_sel", int'(rom_sel), 0);
    rst = 1'b0;

    // Idle lookup
    do_req(0, 0, 1'b0);
    drain();
    chk("idle_busy", int'(busy), 0);

    // One-shot run on word 0
    do_start(0, 1'b0);
    chk("run_busy", int'(busy), 1);
    chk("run_rom_sel", int'(rom_sel), 0);
    do_req(31, 3, 1'b0);
    drain();

    repeat (32) step(8);
    for (int i = 0; i < 11; i++) do_req(vtab[i].x, vtab[i].y, vtab[i].exp_on);
    drain();

    // Back-to-back lookups at offset 50
    repeat (18) step(8);
    for (int i = 0; i < 32; i++) do_req(i, i % 16, exp_pix(i, i % 16));
    drain();

    // Right edge at offset 102, then the one-shot end
    repeat (52) step(8);
    do_req(0, 3, exp_pix(0, 3));
    do_req(0, 0, exp_pix(0, 0));
    do_req(1, 3, 1'b0);
    drain();
    chk("pre_done_busy", int'(busy), 1);
    chk("pre_done_cnt", done_cnt, 0);
    step(8);
    drain();
    chk("oneshot_done_cnt", done_cnt, 1);
    chk("oneshot_busy", int'(busy), 0);
    do_req(0, 3, 1'b0);
    drain();
    chk("oneshot_done_once", done_cnt, 1);

    // Looping run on word 2: 102 wraps to 0 without done
    do_start(2, 1'b1);
    chk("loop_rom_sel", int'(rom_sel), 2);
    repeat (102) step(8);
    do_req(0, 1, exp_pix(0, 1));
    do_req(0, 3, exp_pix(0, 3));
    step(8);
    drain();
    chk("loop_busy", int'(busy), 1);
    chk("loop_no_done", done_cnt, 1);
    do_req(31, 1, exp_pix(31, 1));
    step(8);
    do_req(31, 1, exp_pix(31, 1));
    drain();

    // Coalescing: several wraps, two adjacent frame starts -> exactly one step
    do_start(2, 1'b1);
    repeat (14) tick();
    for (int k = 0; k < 4 && ((cyc - m_start_cyc) % 4) != 0; k++) tick();
    frame_start = 1'b1;
    tick();
    tick();
    frame_start = 1'b0;
    m_off = 1;
    do_req(31, 1, exp_pix(31, 1));
    do_req(30, 1, exp_pix(30, 1));
    drain();

    // In-flight result survives stop
    do_req(31, 1, exp_pix(31, 1));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    m_run = 1'b0;
    chk("stop_busy", int'(busy), 0);
    drain();
    do_req(31, 1, 1'b0);
    drain();

    // start and stop together from RUN: stop wins
    do_start(2, 1'b1);
    chk("restart_busy", int'(busy), 1);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    m_run = 1'b0;
    chk("start_stop_busy", int'(busy), 0);
    do_req(31, 1, 1'b0);
    drain();

    // Reset mid-run flushes the pipeline
    do_start(1, 1'b1);
    repeat (3) step(8);
    pix_req = 1'b1; pix_x = 5'd0; pix_y = 4'd0;
    tick();
    pix_req = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_pix_valid", int'(pix_valid), 0);
    chk("midrst_pix_on", int'(pix_on), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_rom_sel", int'(rom_sel), 0);
    rst = 1'b0;
    m_run = 1'b0; m_off = 0; m_word = 0;
    drain();
    do_req(0, 3, 1'b0);
    drain();

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
